// File: rtl/key_schedule_sequencer_pkg.sv
// key_schedule_sequencer_pkg: AES types, GF(2^8) helpers, S-box and the default round count.
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif
package key_schedule_sequencer_pkg;
  typedef logic [127:0] round_key_t;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as x^254 (multiplicative inverse, 0 maps to 0) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      r = (i != 0) ? gmul(r, x) : r;
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
endpackage

// File: rtl/key_schedule_sequencer_step.sv
// key_expand_step: combinational AES-128 key expansion step (previous round key, rcon -> next round key).
module key_expand_step
  import key_schedule_sequencer_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);
  word_t w_t, w_0, w_1, w_2, w_3;
  assign w_t = sub_word({i_key[23:0], i_key[31:24]}) ^ {i_rcon, 24'h0};
  assign w_0 = i_key[127:96] ^ w_t;
  assign w_1 = i_key[95:64] ^ w_0;
  assign w_2 = i_key[63:32] ^ w_1;
  assign w_3 = i_key[31:0] ^ w_2;
  assign o_key = {w_0, w_1, w_2, w_3};
endmodule

// File: rtl/key_schedule_sequencer.sv
// key_schedule_sequencer: iterative AES key expansion into a parallel round-key bank, one key per clock.
// Optional KEY_SCHED_INVERSE_EN adds inv_round_keys (bank in reversed order for decryption).
`ifndef NUM_ROUNDS
`define NUM_ROUNDS 10
`endif
module key_schedule_sequencer
  import key_schedule_sequencer_pkg::*;
#(
  parameter int NUM_ROUNDS = `NUM_ROUNDS
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [127:0]                  key_in,
  input  logic                          key_in_valid,
  output logic                          key_in_ready,
  output logic                          busy,
  output logic                          keys_valid,
  output logic [(NUM_ROUNDS+1)*128-1:0] round_keys
`ifdef KEY_SCHED_INVERSE_EN
  ,
  output logic [(NUM_ROUNDS+1)*128-1:0] inv_round_keys
`endif
);
  state_t     r_state;
  round_key_t r_bank [NUM_ROUNDS+1];
  logic [3:0] r_cnt;
  logic [7:0] r_rcon;
  logic       r_busy, r_valid;
  round_key_t w_prev, w_next;
  logic       w_accept;

  assign key_in_ready = (r_state != EXPAND);
  assign busy = r_busy;
  assign keys_valid = r_valid;
  assign w_accept = key_in_valid && key_in_ready;

  always_comb begin
    w_prev = '0;
    for (int i = 0; i < NUM_ROUNDS; i++) if (r_cnt == 4'(i + 1)) w_prev = r_bank[i];
  end

  key_expand_step u_step (.i_key(w_prev), .i_rcon(r_rcon), .o_key(w_next));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rcon <= 8'h01;
      r_busy <= 1'b0;
      r_valid <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) r_bank[i] <= '0;
    end else if (w_accept) begin
      r_state <= EXPAND;
      r_bank[0] <= key_in;
      r_cnt <= 4'd1;
      r_rcon <= 8'h01;
      r_busy <= 1'b1;
      r_valid <= 1'b0;
    end else if (r_state == EXPAND) begin
      for (int i = 1; i <= NUM_ROUNDS; i++) if (r_cnt == 4'(i)) r_bank[i] <= w_next;
      r_rcon <= xtime(r_rcon);
      r_cnt <= (r_cnt == 4'hf) ? r_cnt : r_cnt + 4'd1;
      if (r_cnt == 4'(NUM_ROUNDS)) begin
        r_state <= DONE;
        r_busy <= 1'b0;
        r_valid <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i <= NUM_ROUNDS; i++) begin : g_out
    assign round_keys[i*128 +: 128] = r_bank[i];
`ifdef KEY_SCHED_INVERSE_EN
    assign inv_round_keys[i*128 +: 128] = r_bank[NUM_ROUNDS-i];
`endif
  end
endmodule

// File: tb/tb_key_schedule_sequencer.sv
// tb_key_schedule_sequencer: directed FIPS-197 vectors, handshake, async reset and restart checks.
module tb_key_schedule_sequencer;
  localparam int N = 10;
  localparam logic [127:0] KA  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] KA1 = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] KA9 = 128'hac7766f3_19fadc21_28d12941_575c006e;
  localparam logic [127:0] KAT = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] KZ1 = 128'h62636363_62636363_62636363_62636363;
  localparam logic [127:0] KZT = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [127:0] key_in = '0;
  logic key_in_valid = 1'b0;
  logic key_in_ready, busy, keys_valid;
  logic [(N+1)*128-1:0] round_keys;
  int checks = 0;
  int errors = 0;
`ifdef KEY_SCHED_INVERSE_EN
  logic [(N+1)*128-1:0] inv_round_keys;
`endif

  key_schedule_sequencer dut (
    .clock(clock), .reset(reset), .key_in(key_in), .key_in_valid(key_in_valid),
    .key_in_ready(key_in_ready), .busy(busy), .keys_valid(keys_valid), .round_keys(round_keys)
`ifdef KEY_SCHED_INVERSE_EN
    , .inv_round_keys(inv_round_keys)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] rk(input int i);
    return round_keys[i*128 +: 128];
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 128'(key_in_ready), 128'd1);
    check({tag, "_busy"}, 128'(busy), 128'd0);
    check({tag, "_valid"}, 128'(keys_valid), 128'd0);
    for (int i = 0; i <= N; i++) check($sformatf("%s_slot%0d", tag, i), rk(i), '0);
  endtask

  initial begin
    #2;
    check_reset_state("rst");
    #10 reset = 1'b1;
    tick(1);
    // A.1 key accepted, then expansion observed edge by edge
    key_in = KA;
    key_in_valid = 1'b1;
    tick(1);
    key_in_valid = 1'b0;
    check("acc_busy", 128'(busy), 128'd1);
    check("acc_ready", 128'(key_in_ready), 128'd0);
    check("acc_valid", 128'(keys_valid), 128'd0);
    check("acc_slot0", rk(0), KA);
    tick(1);
    check("a1_key1", rk(1), KA1);
    tick(8);
    check("a1_valid_e9", 128'(keys_valid), 128'd0);
    check("a1_busy_e9", 128'(busy), 128'd1);
    tick(1);
    check("a1_valid_e10", 128'(keys_valid), 128'd1);
    check("a1_busy_e10", 128'(busy), 128'd0);
    check("a1_ready_e10", 128'(key_in_ready), 128'd1);
    check("a1_key9", rk(9), KA9);
    check("a1_key10", rk(10), KAT);
`ifdef KEY_SCHED_INVERSE_EN
    check("inv0", inv_round_keys[0 +: 128], KAT);
    check("inv10", inv_round_keys[N*128 +: 128], KA);
`endif
    tick(3);
    check("done_hold", 128'(keys_valid), 128'd1);
    // back-to-back restart with the all-zero key
    key_in = '0;
    key_in_valid = 1'b1;
    tick(1);
    key_in_valid = 1'b0;
    check("b2b_valid_drop", 128'(keys_valid), 128'd0);
    check("b2b_busy", 128'(busy), 128'd1);
    check("b2b_slot0", rk(0), '0);
    tick(10);
    check("b2b_valid", 128'(keys_valid), 128'd1);
    check("zero_key1", rk(1), KZ1);
    check("zero_key10", rk(10), KZT);
    // a different key held valid during expansion must be ignored
    key_in = KA;
    key_in_valid = 1'b1;
    tick(1);
    key_in = ~KA;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("hs_ready_e%0d", i + 1), 128'(key_in_ready), 128'd0);
      tick(1);
    end
    key_in_valid = 1'b0;
    tick(2);
    check("hs_valid", 128'(keys_valid), 128'd1);
    check("hs_slot0", rk(0), KA);
    check("hs_key1", rk(1), KA1);
    check("hs_key10", rk(10), KAT);
    // asynchronous reset in the middle of expansion
    key_in = KA;
    key_in_valid = 1'b1;
    tick(1);
    key_in_valid = 1'b0;
    tick(5);
    check("mid_busy", 128'(busy), 128'd1);
    #2 reset = 1'b0;
    #1;
    check_reset_state("mid_rst");
    #3 reset = 1'b1;
    tick(2);
    check("post_rst_idle", 128'(busy), 128'd0);
    check("post_rst_slot1", rk(1), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
